// File: rtl/sprite_motion_pkg.sv
// Shared encodings and widths for the sprite motion controller.
package sprite_motion_pkg;

   localparam int COORD_W = 10;
   localparam int VEL_W   = 5;

   typedef enum logic [1:0] {
      OP_SET_POS = 2'd0,
      OP_SET_VEL = 2'd1,
      OP_ENABLE  = 2'd2,
      OP_HALT    = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_STEP_X = 2'd2,
      ST_STEP_Y = 2'd3
   } state_e;

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis motion step with edge bounce; shared between X and Y by the FSM.
module sprite_axis_step
   import sprite_motion_pkg::*;
(
   input  logic [COORD_W-1:0] pos,
   input  logic [VEL_W-1:0]   vel,
   input  logic [COORD_W-1:0] max,
   output logic [COORD_W-1:0] new_pos,
   output logic [VEL_W-1:0]   new_vel,
   output logic               bounce
);

   // One extra bit so an underflow below zero shows up as the sign bit.
   logic [COORD_W:0] nx;
   logic [VEL_W-1:0] vel_neg;

   assign nx = {1'b0, pos} + {{(COORD_W + 1 - VEL_W){vel[VEL_W-1]}}, vel};

   // Negating the most negative velocity would overflow, so it saturates.
   assign vel_neg = (vel == {1'b1, {(VEL_W-1){1'b0}}}) ? {1'b0, {(VEL_W-1){1'b1}}}
                                                       : (~vel) + VEL_W'(1);

   // Clamp to the playfield and reflect velocity when the step leaves it.
   always_comb begin
      new_pos = nx[COORD_W-1:0];
      new_vel = vel;
      bounce  = 1'b0;
      if (nx[COORD_W]) begin
         new_pos = '0;
         new_vel = vel_neg;
         bounce  = 1'b1;
      end else if (nx[COORD_W-1:0] > max) begin
         new_pos = max;
         new_vel = vel_neg;
         bounce  = 1'b1;
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite motion controller: host commands land in shadow
// registers and are committed, then stepped, once per frame_start.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | accept host commands, wait for frame_start
// ST_APPLY  | commit shadow regs to live, advance frame divider
// ST_STEP_X | step X with bounce (if this frame steps)
// ST_STEP_Y | step Y with bounce (if this frame steps)
module sprite_motion_ctrl
   import sprite_motion_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int SPR_SIZE  = 32,
   parameter int FRAME_DIV = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [19:0]          cmd_data,
   output logic [COORD_W-1:0]   spr_x,
   output logic [COORD_W-1:0]   spr_y,
   output logic                 spr_en,
   output logic                 busy,
   output logic                 bounce_x,
   output logic                 bounce_y
);

   localparam logic [COORD_W-1:0] MAX_X = COORD_W'(H_ACTIVE - SPR_SIZE);
   localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(V_ACTIVE - SPR_SIZE);
   localparam logic [COORD_W-1:0] CTR_X = COORD_W'((H_ACTIVE - SPR_SIZE) / 2);
   localparam logic [COORD_W-1:0] CTR_Y = COORD_W'((V_ACTIVE - SPR_SIZE) / 2);
   localparam logic [3:0]         DIV_LAST = 4'(FRAME_DIV - 1);

   state_e             state;
   logic [VEL_W-1:0]   vx, vy;
   logic [COORD_W-1:0] sh_x, sh_y;
   logic [VEL_W-1:0]   sh_vx, sh_vy;
   logic               sh_en;
   logic               pos_pending;
   logic               step_act;
   logic [3:0]         div;

   logic [COORD_W-1:0] ax_pos, ax_max, ax_new_pos;
   logic [VEL_W-1:0]   ax_vel, ax_new_vel;
   logic               ax_bounce;
   logic [COORD_W-1:0] cmd_x, cmd_y;

   assign cmd_ready = (state == ST_IDLE) && !frame_start;

   assign cmd_x = (cmd_data[9:0]   > MAX_X) ? MAX_X : cmd_data[9:0];
   assign cmd_y = (cmd_data[19:10] > MAX_Y) ? MAX_Y : cmd_data[19:10];

   // Route the live axis selected by the current STEP state into the stepper.
   always_comb begin
      ax_pos = spr_x;
      ax_vel = vx;
      ax_max = MAX_X;
      if (state == ST_STEP_Y) begin
         ax_pos = spr_y;
         ax_vel = vy;
         ax_max = MAX_Y;
      end
   end

   sprite_axis_step u_step (
      .pos     (ax_pos),
      .vel     (ax_vel),
      .max     (ax_max),
      .new_pos (ax_new_pos),
      .new_vel (ax_new_vel),
      .bounce  (ax_bounce)
   );

   // Sequencer, shadow/live register file and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         spr_x       <= CTR_X;
         spr_y       <= CTR_Y;
         vx          <= '0;
         vy          <= '0;
         spr_en      <= 1'b0;
         sh_x        <= CTR_X;
         sh_y        <= CTR_Y;
         sh_vx       <= '0;
         sh_vy       <= '0;
         sh_en       <= 1'b0;
         pos_pending <= 1'b0;
         step_act    <= 1'b0;
         div         <= '0;
         busy        <= 1'b0;
         bounce_x    <= 1'b0;
         bounce_y    <= 1'b0;
      end else begin
         bounce_x <= 1'b0;
         bounce_y <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  state <= ST_APPLY;
                  busy  <= 1'b1;
               end else if (cmd_valid) begin
                  case (cmd_op_e'(cmd_op))
                     OP_SET_POS: begin
                        sh_x        <= cmd_x;
                        sh_y        <= cmd_y;
                        pos_pending <= 1'b1;
                     end
                     OP_SET_VEL: begin
                        sh_vx <= cmd_data[4:0];
                        sh_vy <= cmd_data[9:5];
                     end
                     OP_ENABLE: sh_en <= cmd_data[0];
                     OP_HALT: begin
                        sh_vx <= '0;
                        sh_vy <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_APPLY: begin
               vx     <= sh_vx;
               vy     <= sh_vy;
               spr_en <= sh_en;
               if (pos_pending) begin
                  spr_x       <= sh_x;
                  spr_y       <= sh_y;
                  pos_pending <= 1'b0;
               end
               // A freshly placed sprite is not stepped in the same frame.
               step_act <= (div == DIV_LAST) && !pos_pending;
               div      <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
               state    <= ST_STEP_X;
            end
            ST_STEP_X: begin
               if (step_act) begin
                  spr_x <= ax_new_pos;
                  vx    <= ax_new_vel;
                  if (ax_bounce) begin
                     sh_vx    <= ax_new_vel;
                     bounce_x <= 1'b1;
                  end
               end
               state <= ST_STEP_Y;
            end
            ST_STEP_Y: begin
               if (step_act) begin
                  spr_y <= ax_new_pos;
                  vy    <= ax_new_vel;
                  if (ax_bounce) begin
                     sh_vy    <= ax_new_vel;
                     bounce_y <= 1'b1;
                  end
               end
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl; a second instance runs with FRAME_DIV=2.
module tb_sprite_motion_ctrl;

   localparam logic [1:0] OP_POS = 2'd0;
   localparam logic [1:0] OP_VEL = 2'd1;
   localparam logic [1:0] OP_EN  = 2'd2;
   localparam logic [1:0] OP_HLT = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'd0;
   logic [19:0] cmd_data = 20'd0;

   logic        cmd_ready, spr_en, busy, bounce_x, bounce_y;
   logic [9:0]  spr_x, spr_y;
   logic        cmd_ready2, spr_en2, busy2, bounce_x2, bounce_y2;
   logic [9:0]  spr_x2, spr_y2;

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cnt, x_at1, n_wait;
   logic bx_seen, by_seen, bx_at2;

   sprite_motion_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .busy(busy),
      .bounce_x(bounce_x), .bounce_y(bounce_y)
   );

   sprite_motion_ctrl #(.FRAME_DIV(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .spr_x(spr_x2), .spr_y(spr_y2), .spr_en(spr_en2), .busy(busy2),
      .bounce_x(bounce_x2), .bounce_y(bounce_y2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [19:0] data);
      logic done;
      done      = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) begin
            tick();
            done = 1'b1;
            break;
         end
         tick();
      end
      cmd_valid = 1'b0;
      if (!done) chk("cmd_accept_timeout", 0, 1);
   endtask

   // Pulse frame_start and watch the three busy cycles plus return to idle.
   task automatic run_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      busy_cnt = busy ? 1 : 0;
      bx_seen  = bounce_x;
      by_seen  = bounce_y;
      bx_at2   = 1'b0;
      x_at1    = 0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (busy) busy_cnt++;
         bx_seen = bx_seen | bounce_x;
         by_seen = by_seen | bounce_y;
         if (k == 1) x_at1 = int'(spr_x);
         if (k == 2) bx_at2 = bounce_x;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      chk("rst_spr_x", int'(spr_x), 304);
      chk("rst_spr_y", int'(spr_y), 224);
      chk("rst_spr_en", int'(spr_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);

      // vx=+3, vy=-2
      send_cmd(OP_VEL, 20'd963);
      run_frame();
      chk("vel_x_before_step", x_at1, 304);
      chk("vel_spr_x", int'(spr_x), 307);
      chk("vel_spr_y", int'(spr_y), 222);
      chk("vel_busy_cycles", busy_cnt, 3);
      chk("vel_no_bounce", int'(bx_seen), 0);

      send_cmd(OP_EN, 20'd1);
      chk("en_shadow_only", int'(spr_en), 0);

      // Right-edge bounce
      send_cmd(OP_POS, (20'd100 << 10) | 20'd606);
      send_cmd(OP_VEL, 20'd5);
      run_frame();
      chk("rb_f1_x", int'(spr_x), 606);
      chk("rb_f1_y", int'(spr_y), 100);
      chk("rb_f1_en", int'(spr_en), 1);
      chk("rb_f1_bounce", int'(bx_seen), 0);
      run_frame();
      chk("rb_f2_x", int'(spr_x), 608);
      chk("rb_f2_bounce_t2", int'(bx_at2), 1);
      chk("rb_f2_bounce_y", int'(by_seen), 0);
      run_frame();
      chk("rb_f3_x", int'(spr_x), 603);
      chk("rb_f3_bounce", int'(bx_seen), 0);

      // Left-edge bounce with vx=-16 saturating to +15
      send_cmd(OP_POS, (20'd100 << 10) | 20'd10);
      send_cmd(OP_VEL, 20'd16);
      run_frame();
      chk("sat_f1_x", int'(spr_x), 10);
      run_frame();
      chk("sat_f2_x", int'(spr_x), 0);
      chk("sat_f2_bounce", int'(bx_seen), 1);
      run_frame();
      chk("sat_f3_x", int'(spr_x), 15);
      chk("sat_f3_bounce", int'(bx_seen), 0);

      send_cmd(OP_HLT, 20'd0);
      run_frame();
      chk("halt_x", int'(spr_x), 15);

      // Bottom-edge bounce, vy=+4
      send_cmd(OP_POS, (20'd446 << 10) | 20'd100);
      send_cmd(OP_VEL, 20'd128);
      run_frame();
      chk("yb_f1_y", int'(spr_y), 446);
      run_frame();
      chk("yb_f2_y", int'(spr_y), 448);
      chk("yb_f2_bounce_y", int'(by_seen), 1);
      chk("yb_f2_bounce_x", int'(bx_seen), 0);
      run_frame();
      chk("yb_f3_y", int'(spr_y), 444);

      // Out-of-range position clamps to the maximum
      send_cmd(OP_POS, (20'd1000 << 10) | 20'd1000);
      run_frame();
      chk("clamp_x", int'(spr_x), 608);
      chk("clamp_y", int'(spr_y), 448);

      // Command collides with frame_start
      cmd_valid   = 1'b1;
      cmd_op      = OP_EN;
      cmd_data    = 20'd0;
      frame_start = 1'b1;
      #1;
      chk("coll_ready_low", int'(cmd_ready), 0);
      tick();
      frame_start = 1'b0;
      n_wait = 0;
      while (!cmd_ready && n_wait < 10) begin
         tick();
         n_wait++;
      end
      chk("coll_stall_cycles", n_wait, 3);
      chk("coll_busy_idle", int'(busy), 0);
      tick();
      cmd_valid = 1'b0;
      chk("coll_en_unchanged", int'(spr_en), 1);
      run_frame();
      chk("coll_en_applied", int'(spr_en), 0);

      // FRAME_DIV=2 on the second instance
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      send_cmd(OP_VEL, 20'd1);
      run_frame();
      chk("div1_x", int'(spr_x), 305);
      chk("div2_f1_x", int'(spr_x2), 304);
      run_frame();
      chk("div2_f2_x", int'(spr_x2), 305);
      run_frame();
      chk("div2_f3_x", int'(spr_x2), 305);
      run_frame();
      chk("div2_f4_x", int'(spr_x2), 306);

      // Reset in STEP_X of a frame that would bounce
      send_cmd(OP_POS, (20'd100 << 10) | 20'd600);
      send_cmd(OP_VEL, 20'd15);
      send_cmd(OP_EN, 20'd1);
      run_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      chk("mid_pre_x", int'(spr_x), 600);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_x", int'(spr_x), 304);
      chk("mid_rst_y", int'(spr_y), 224);
      chk("mid_rst_en", int'(spr_en), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_bounce", int'(bounce_x), 0);
      tick();
      chk("mid_rst_bounce_hold", int'(bounce_x), 0);
      rst_n = 1'b1;
      tick();
      run_frame();
      chk("post_rst_x", int'(spr_x), 304);
      chk("post_rst_bounce", int'(bx_seen), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Frame-synchronous motion controller for the 32x32 sprite overlay in the VGA colour-bar display. It accepts host commands for position, velocity and enable over a valid/ready port and holds them in shadow registers. On each frame-start pulse it commits the shadow registers, then steps the sprite with edge bounce. It drives sprite X/Y to the pixel compositor, so position never changes mid-frame.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
SPR_SIZE, 32, sprite edge length in pixels
FRAME_DIV, 1, motion steps once every FRAME_DIV frames (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse from the timing generator at vertical-blank start
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
cmd_op  in  2  0=SET_POS, 1=SET_VEL, 2=ENABLE, 3=HALT
cmd_data  in  20  operand
spr_x  out  10  sprite left edge, 0..H_ACTIVE-SPR_SIZE
spr_y  out  10  sprite top edge, 0..V_ACTIVE-SPR_SIZE
spr_en  out  1  sprite visible
busy  out  1  frame update in progress
bounce_x  out  1  one-cycle pulse on X edge reflection
bounce_y  out  1  one-cycle pulse on Y edge reflection

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - spr_x=(H_ACTIVE-SPR_SIZE)/2 (304); spr_y=(V_ACTIVE-SPR_SIZE)/2 (224)
  - vx=vy=0; spr_en=0; busy=0; bounce_x=bounce_y=0
  - shadow registers equal the live registers; pos_pending=0; frame divider=0; state=IDLE
- FSM states: IDLE -> APPLY -> STEP_X -> STEP_Y -> IDLE.
  - IDLE -> APPLY on frame_start.
  - All other transitions are unconditional, one cycle each.
- busy is high in APPLY, STEP_X and STEP_Y.
- frame_start outside IDLE is ignored and is not queued.
- cmd_ready = (state==IDLE) && !frame_start. If a command and frame_start coincide, frame_start wins; the command stalls until the next IDLE cycle.
- Commands (write shadow registers only; live registers are untouched until APPLY):
  - SET_POS: sh_x=data[9:0], sh_y=data[19:10], each clamped to its max; sets pos_pending.
  - SET_VEL: sh_vx=data[4:0], sh_vy=data[9:5], two's complement, range -16..+15.
  - ENABLE: sh_en=data[0].
  - HALT: sh_vx=sh_vy=0.
  - Last write before APPLY wins.
- APPLY:
  - live vx, vy, en <= shadow.
  - If pos_pending: spr_x/spr_y <= shadow, pos_pending cleared, and both STEP states are no-ops this frame.
  - The frame divider increments in APPLY. A STEP is active only when the divider wraps at FRAME_DIV-1 -> 0.
- STEP_X arithmetic (STEP_Y is identical with y, vy, maxy):
  - nx = {1'b0,spr_x} + sext(vx), computed at 11 bits signed.
  - maxx = H_ACTIVE-SPR_SIZE (608); maxy = V_ACTIVE-SPR_SIZE (448).
  - nx<0: spr_x=0, vx=neg(vx), bounce_x pulses.
  - nx>maxx: spr_x=maxx, vx=neg(vx), bounce_x pulses.
  - Otherwise spr_x=nx.
  - neg(-16) saturates to +15.
  - Landing exactly on 0 or max is not a bounce.
- Latency: frame_start sampled at edge T.
  - APPLY results visible after T+2.
  - spr_x visible after T+3; spr_y visible after T+4.
  - bounce pulses are high for the cycle after their STEP state.
- The shadow velocity register tracks reflections so the next commit does not undo a bounce. A host SET_VEL in the same frame overrides the reflection.
- Reset mid-operation returns every register to its reset value immediately; the partial update is discarded.

Decomposition:
- Package sprite_motion_pkg:
  - cmd_op encodings (OP_SET_POS, OP_SET_VEL, OP_ENABLE, OP_HALT)
  - FSM state enum
  - coordinate width 10 and velocity width 5 constants
- Sub-module sprite_axis_step (pure combinational):
  - inputs: pos, vel, max
  - outputs: new_pos, new_vel, bounce
  - one instance, muxed between the X and Y axes by state.

Test Plan:
- Reset release -> spr_x=304, spr_y=224, spr_en=0, busy=0, cmd_ready=1.
- SET_VEL vx=+3 vy=-2, then frame_start -> spr_x=307 after T+3, spr_y=222 after T+4, busy high 3 cycles.
- X bounce at right edge:
  - SET_POS x=606 y=100 plus vx=+5, frame_start -> first frame x=606 (no step).
  - Second frame -> x=608, vx=-5, bounce_x pulse.
  - Third frame -> x=603.
- Saturated reflection: x=10, vx=-16, frame_start -> x=0, vx=+15, bounce_x; next frame x=15.
- Command collision and FRAME_DIV=2:
  - cmd_valid held with frame_start in the same cycle -> cmd_ready=0; accepted on the first IDLE cycle after STEP_Y.
  - FRAME_DIV=2 -> position changes on alternate frames only.
- Reset mid-update: assert rst_n=0 during STEP_X -> outputs return to reset values immediately; no bounce pulse.
